ahb_sram_slave: RTL
===================

# ahb_sram_slave

Parametrised AHB-Lite slave wrapping an internal byte-addressable SRAM array. It is the next generation of the team's AHB-to-RAM bridge and adds:
- true byte-lane writes, with read-after-write forwarding through a two-port array;
- an optional registered read path with one wait state;
- AHB ERROR responses for out-of-range addresses and oversized transfers.

It sits on an AHB-Lite interconnect as a memory slave. Data phase and memory write are pipelined one cycle behind the address phase.

## Interface
- HADDR_SIZE, 32, address width
- HDATA_SIZE, 32, data width; one of 8/16/32/64/128; BE_SIZE = HDATA_SIZE/8
- MEM_DEPTH, 1024, number of HDATA_SIZE-wide words; power of two; MEM_ABITS = log2(MEM_DEPTH)
- READ_WAIT, 0, 0 = HRDATA straight from array read port, no wait; 1 = registered HRDATA, one wait state per read
- ERR_ON_OOR, 1, 1 = ERROR response when word address >= MEM_DEPTH; 0 = address wraps modulo MEM_DEPTH

Ports:
- HCLK  in  1  clock; all state on rising edge
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  HADDR_SIZE  byte address
- HWDATA  in  HDATA_SIZE  write data (data phase)
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size, 2^HSIZE bytes
- HBURST  in  3  burst type; accepted, not used for addressing
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- HREADY  in  1  bus ready
- HRDATA  out  HDATA_SIZE  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR

## Operation
- A transfer is accepted when HSEL & HREADY & HTRANS[1] (NONSEQ or SEQ). IDLE and BUSY are accepted with a zero-wait OKAY and have no side effects.
- Address phase registers:
  - word address HADDR[LSB +: MEM_ABITS], where LSB = log2(BE_SIZE);
  - write flag;
  - byte enable be = ((1 << 2^HSIZE) - 1) << (HADDR & (BE_SIZE-1)), truncated to BE_SIZE bits.
- Error check, evaluated in the address phase:
  - 2^HSIZE > BE_SIZE is an error;
  - with ERR_ON_OOR=1, HADDR >> LSB >= MEM_DEPTH is an error.
  - Erroring transfers do not write memory and do not update the forwarding registers.
- Write: the array is written at the end of the data phase, using HWDATA and the registered be. Lanes with be[n]=0 are unchanged.
- Read: the array read port is addressed from HADDR in the address phase (READ_WAIT=0), or from the registered address (READ_WAIT=1).
- Forwarding: if a read's word address equals the word address of the write in its immediately preceding data phase, the returned data is built per byte lane:
  - lanes where that write's be[n]=1 take the written bytes;
  - all other lanes take the array data.
  - Back-to-back writes to the same word merge correctly.
- State machine:
  - IDLE: no data phase pending.
    - Accepted OK read with READ_WAIT=1 -> RWAIT.
    - Accepted error -> ERR1.
    - Otherwise -> IDLE, or stay in data phase with zero wait.
  - RWAIT: HREADYOUT=0; HRDATA register loads. Next state -> IDLE, data phase completes with HREADYOUT=1.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. An address phase presented in ERR2 is ignored (master cancels) -> IDLE.
- Memory contents are not reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, pending write cleared.
- Reset asserted mid-transfer drops any pending write. The array is untouched by that write.
- READ_WAIT=0:
  - read data valid in the cycle after the address phase, zero wait states;
  - write zero wait.
- READ_WAIT=1:
  - reads take 2 cycles of data phase (one with HREADYOUT=0);
  - writes remain zero wait.
- A write data phase overlapping a read address phase is handled by the two-port array plus forwarding. No stall.
- HREADY=0 from another slave: no new transfer is accepted, and a pending write holds until its data phase completes.
- An error costs exactly 2 data-phase cycles.

## Test plan
- After reset, check HREADYOUT=1, HRESP=0, HRDATA=0. Write word 0x0000_0010 = 0xDEADBEEF, then read 0x10 -> 0xDEADBEEF.
- Write 0xFFFFFFFF to 0x20, then byte write HSIZE=0 at 0x21 with HWDATA=0x0000_5A00, then read 0x20 -> 0xFFFF5AFF.
- Pipelined write 0x30=0x11223344 immediately followed by a read of 0x30 (read address phase = write data phase) -> read returns 0x11223344 with no wait. Repeat with a halfword write at 0x32 -> merged lanes correct.
- ERR_ON_OOR=1, MEM_DEPTH=1024: write to 0x1000 -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1. A subsequent read of 0x000 shows it unchanged.
- HSIZE=3 (64-bit) on a 32-bit bus -> two-cycle ERROR, no write.
- READ_WAIT=1: NONSEQ read followed by SEQ read -> each read's data phase holds HREADYOUT=0 for 1 cycle and returns correct data. Insert BUSY between them -> OKAY, no effect. Assert HRESETn low during RWAIT -> outputs return to reset values.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM slave with byte-lane writes and read-after-write forwarding
// Optional registered read path (READ_WAIT=1) and two-cycle ERROR responses.
module ahb_sram_slave #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int READ_WAIT  = 0,
  parameter int ERR_ON_OOR = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int BE_SIZE   = HDATA_SIZE / 8;
  localparam int LSB       = $clog2(BE_SIZE);
  localparam int MEM_ABITS = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RWAIT = 2'd1,
    ST_ERR1  = 2'd2,
    ST_ERR2  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_hreadyout;
  logic                   w_hresp;

  logic                   w_accept;
  logic                   w_size_err;
  logic                   w_oor;
  logic                   w_err;
  logic                   w_rd_ok;
  logic [MEM_ABITS-1:0]   w_waddr;
  logic [HADDR_SIZE-1:0]  w_haddr_hi;
  logic [BE_SIZE-1:0]     w_be;
  int                     w_off;
  int                     w_nbytes;

  logic                   r_we;
  logic [MEM_ABITS-1:0]   r_waddr;
  logic [BE_SIZE-1:0]     r_be;

  logic [HDATA_SIZE-1:0]  r_mem [MEM_DEPTH];
  logic [HDATA_SIZE-1:0]  r_arr_q;
  logic [HDATA_SIZE-1:0]  r_hrdata;
  logic                   r_fwd_hit;
  logic [BE_SIZE-1:0]     r_fwd_be;
  logic [HDATA_SIZE-1:0]  r_fwd_data;
  logic [HDATA_SIZE-1:0]  w_fwd_rdata;

  logic                   w_unused;

  // Address phases presented while an error or read wait is in progress are ignored.
  assign w_accept   = HSEL & HREADY & HTRANS[1] & (r_state == ST_IDLE);
  assign w_waddr    = HADDR[LSB +: MEM_ABITS];
  assign w_haddr_hi = HADDR >> (LSB + MEM_ABITS);
  assign w_size_err = int'(HSIZE) > LSB;
  assign w_oor      = (ERR_ON_OOR != 0) && (w_haddr_hi != '0);
  assign w_err      = w_size_err | w_oor;
  assign w_rd_ok    = w_accept & ~w_err & ~HWRITE;

  assign w_off    = int'(HADDR) & (BE_SIZE - 1);
  assign w_nbytes = 1 << HSIZE;

  always_comb begin
    w_be = '0;
    for (int n = 0; n < BE_SIZE; n++) begin
      w_be[n] = (n >= w_off) && (n < w_off + w_nbytes);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hreadyout = 1'b1;
    w_hresp     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_err) begin
            w_state_nxt = ST_ERR1;
          end else if (!HWRITE && (READ_WAIT != 0)) begin
            w_state_nxt = ST_RWAIT;
          end
        end
      end
      ST_RWAIT: begin
        w_hreadyout = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      ST_ERR1: begin
        w_hreadyout = 1'b0;
        w_hresp     = 1'b1;
        w_state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        w_hresp     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The pending write holds while the bus is stalled and commits when HREADY closes its data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_be    <= '0;
    end else if (HREADY) begin
      r_we <= w_accept & ~w_err & HWRITE;
      if (w_accept) begin
        r_waddr <= w_waddr;
        r_be    <= w_be;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (r_we && HREADY) begin
      for (int n = 0; n < BE_SIZE; n++) begin
        if (r_be[n]) begin
          r_mem[r_waddr][8*n +: 8] <= HWDATA[8*n +: 8];
        end
      end
    end
  end

  // The array read races the write committing on the same edge, so capture that write for merging.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_arr_q    <= '0;
      r_fwd_hit  <= 1'b0;
      r_fwd_be   <= '0;
      r_fwd_data <= '0;
    end else if (w_rd_ok) begin
      r_arr_q    <= r_mem[w_waddr];
      r_fwd_hit  <= r_we && (r_waddr == w_waddr);
      r_fwd_be   <= r_be;
      r_fwd_data <= HWDATA;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hrdata <= '0;
    end else if (r_state == ST_RWAIT) begin
      r_hrdata <= r_mem[r_waddr];
    end
  end

  always_comb begin
    w_fwd_rdata = r_arr_q;
    for (int n = 0; n < BE_SIZE; n++) begin
      if (r_fwd_hit && r_fwd_be[n]) begin
        w_fwd_rdata[8*n +: 8] = r_fwd_data[8*n +: 8];
      end
    end
  end

  assign HRDATA    = (READ_WAIT != 0) ? r_hrdata : w_fwd_rdata;
  assign HREADYOUT = w_hreadyout;
  assign HRESP     = w_hresp;

  assign w_unused = ^{HBURST, HTRANS[0]};

endmodule
